wb_stage: RTL
=============

# wb_stage

Writeback stage of the five-stage pipeline, directly downstream of the memory stage. Accepts one retiring instruction per handshake from the `mem_stage_if` bundle, waits for load data returning from the data RAM when the instruction is a load, and sign- or zero-extends that data. Drives the single register-file write port and the commit/debug trace. Holds at most one instruction and back-pressures the memory stage while a load response is outstanding.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 256: maximum number of WAIT cycles before a load is abandoned. Legal range is 2..65535.
- Widths come from `width_param.sv`: `ADDR_WIDTH`, `INST_WIDTH`, `DATA_WIDTH` (32), `REG_WIDTH` (5).

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `mem_in`  in  `mem_stage_if.i`  carries `pc`, `inst`, `ram_rd_en`, `rw_data`, `rw_addr`, `rw_en`.
  - For a load (`ram_rd_en`=1), `rw_data` holds the effective byte address.
  - Otherwise, `rw_data` holds the result to write.
- `mem_valid`  in  1  the `mem_in` contents are valid this cycle.
- `wb_allowin`  out  1  this stage accepts `mem_in` this cycle.
- `ram_rdata`  in  `DATA_WIDTH`  data RAM read word (word-aligned).
- `ram_rvalid`  in  1  `ram_rdata` is valid this cycle.
- `rf_we`  out  1  register-file write enable.
- `rf_waddr`  out  `REG_WIDTH`  register-file write address.
- `rf_wdata`  out  `DATA_WIDTH`  register-file write data.
- `wb_valid`  out  1  an instruction commits this cycle.
- `wb_pc`  out  `ADDR_WIDTH`  PC of the committing instruction.
- `wb_inst`  out  `INST_WIDTH`  instruction word of the committing instruction.
- `wb_err`  out  1  sticky flag, set on a load timeout.

## Operation
- Accept condition: `mem_valid && wb_allowin`. On accept, latch `pc`, `inst`, `ram_rd_en`, `rw_data`, `rw_addr`, `rw_en`.
- `wb_allowin` = (state==IDLE) || (state==RETIRE). It is 0 while `rst_n`=0.
- FSM states: IDLE, WAIT, RETIRE.
  - IDLE: accept a non-load -> RETIRE; accept a load -> WAIT; no accept -> IDLE.
  - WAIT: on `ram_rvalid`, latch the extended data -> RETIRE. If the timeout counter reaches `TIMEOUT_CYCLES`-1 with no `ram_rvalid`, set `wb_err` and force write-suppress -> RETIRE.
  - RETIRE: commit for exactly one cycle. Same-cycle accept -> WAIT or RETIRE according to the new instruction's type; otherwise -> IDLE.
- Commit outputs, asserted only in RETIRE:
  - `wb_valid`=1.
  - `wb_pc` and `wb_inst` from the held instruction.
  - `rf_we` = `rw_en` && (`rw_addr`!=0) && !timeout.
- Load extension is decoded from held `inst[31:22]`; `a` is the low two bits of the held address.
  - 0x0A0 ld.b: byte `a`, sign-extended.
  - 0x0A8 ld.bu: byte `a`, zero-extended.
  - 0x0A1 ld.h: half selected by `a[1]`, sign-extended.
  - 0x0A9 ld.hu: half selected by `a[1]`, zero-extended.
  - 0x0A2 ld.w: full word; `a` is ignored.
  - Any other opcode with `ram_rd_en`=1: treated as ld.w.
- Byte lane `k` of the RAM word is `ram_rdata[8k+7:8k]`. `a[0]` is ignored for halfwords; misalignment traps upstream.
- Timeout counter:
  - 16 bits wide.
  - Cleared on entry to WAIT.
  - Increments each WAIT cycle without `ram_rvalid`.
- `ram_rvalid` outside WAIT is ignored and has no side effect.
- `wb_err` is cleared only by reset.

## Timing
- Reset values (while `rst_n`=0 and on the first cycle after release): state IDLE; `rf_we`, `rf_waddr`, `rf_wdata`, `wb_valid`, `wb_pc`, `wb_inst` all 0; `wb_err` 0. `wb_allowin` is 0 during reset and 1 in the first cycle after release.
- Non-load accepted at edge N: commit is visible in cycle N+1.
- Load: with `ram_rvalid` sampled at edge M in WAIT, commit is visible in cycle M+1. The minimum load latency, accept to commit, is 2 cycles.
- Back-to-back non-loads: one commit per cycle, with `wb_allowin` continuously 1.
- While in WAIT, `wb_allowin`=0. The upstream must hold `mem_in` and `mem_valid` stable.
- `ram_rvalid` in the same cycle as WAIT entry (accept edge) is not sampled. The response must arrive at or after the first WAIT cycle.
- Timeout: commit occurs `TIMEOUT_CYCLES`+1 cycles after accept, with `rf_we`=0, `wb_valid`=1, and `wb_err` rising in the same cycle.
- Reset asserted mid-WAIT: the held instruction is dropped with no commit. A late `ram_rvalid` after reset is ignored.

## Test plan
- Reset, then a non-load: pc=0x1c000000, rw_addr=5, rw_en=1, rw_data=0xDEADBEEF. Expect at cycle+1: `rf_we`=1, waddr=5, wdata=0xDEADBEEF, `wb_valid`=1, `wb_pc`=0x1c000000.
- ld.b with address 0x...3 and `ram_rdata`=0x80FF7F01, rvalid on the 3rd WAIT cycle. Expect `wb_allowin`=0 for 3 cycles, then wdata=0xFFFFFF80. Repeat as ld.bu: wdata=0x00000080.
- ld.h / ld.hu with address low bits 2 and `ram_rdata`=0x9ABC1234: wdata=0xFFFF9ABC / 0x00009ABC. ld.w at address 1: wdata=0x9ABC1234.
- Three back-to-back non-loads, the second with rw_addr=0. Expect 3 consecutive commits with `wb_valid`=1 each cycle, and `rf_we`=1,0,1.
- Timeout with `TIMEOUT_CYCLES`=4 and a load that is never answered. Expect commit 5 cycles after accept with `rf_we`=0 and `wb_err`=1 held. A later `ram_rvalid` in IDLE produces no effect.
- Assert `rst_n`=0 for one cycle mid-WAIT, then deliver `ram_rvalid`. Expect no commit, all outputs 0, and `wb_allowin`=1 after release.

Source files
------------

// File: rtl/wb_stage_if.sv
// Shared pipeline widths and the memory-stage to writeback-stage handoff bundle.
package width_param;
    localparam int ADDR_WIDTH = 32;
    localparam int INST_WIDTH = 32;
    localparam int DATA_WIDTH = 32;
    localparam int REG_WIDTH  = 5;
endpackage

interface mem_stage_if;
    logic [width_param::ADDR_WIDTH-1:0] pc;
    logic [width_param::INST_WIDTH-1:0] inst;
    logic                               ram_rd_en;
    logic [width_param::DATA_WIDTH-1:0] rw_data;
    logic [width_param::REG_WIDTH-1:0]  rw_addr;
    logic                               rw_en;

    modport i (input  pc, inst, ram_rd_en, rw_data, rw_addr, rw_en);
    modport o (output pc, inst, ram_rd_en, rw_data, rw_addr, rw_en);
endinterface

// File: rtl/wb_stage.sv
// Writeback stage: holds one retiring instruction, waits for and extends load data,
// then commits it to the register file and the trace port for exactly one cycle.
module wb_stage
    import width_param::*;
#(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mem_stage_if.i                mem_in,
    input  logic                  mem_valid,
    output logic                  wb_allowin,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    input  logic                  ram_rvalid,
    output logic                  rf_we,
    output logic [REG_WIDTH-1:0]  rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    output logic                  wb_valid,
    output logic [ADDR_WIDTH-1:0] wb_pc,
    output logic [INST_WIDTH-1:0] wb_inst,
    output logic                  wb_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RETIRE
    } state_t;

    localparam logic [15:0] LP_CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t                r_state;
    state_t                w_next;

    logic [ADDR_WIDTH-1:0] r_pc;
    logic [INST_WIDTH-1:0] r_inst;
    logic                  r_is_load;
    logic [DATA_WIDTH-1:0] r_rw_data;
    logic [REG_WIDTH-1:0]  r_rw_addr;
    logic                  r_rw_en;
    logic [DATA_WIDTH-1:0] r_ldata;
    logic [15:0]           r_cnt;
    logic                  r_timeout;
    logic                  r_err;

    logic                  w_accept;
    logic                  w_timeout_hit;
    logic                  w_retire;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [DATA_WIDTH-1:0] w_ext;

    assign w_accept      = mem_valid && wb_allowin;
    assign w_timeout_hit = (r_state == S_WAIT) && !ram_rvalid && (r_cnt == LP_CNT_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = mem_in.ram_rd_en ? S_WAIT : S_RETIRE;
                end
            end
            S_WAIT: begin
                if (ram_rvalid || w_timeout_hit) begin
                    w_next = S_RETIRE;
                end
            end
            S_RETIRE: begin
                if (w_accept) begin
                    w_next = mem_in.ram_rd_en ? S_WAIT : S_RETIRE;
                end else begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Outputs are gated by rst_n so they read as zero during reset, before the first edge.
    always_comb begin
        wb_allowin = rst_n && ((r_state == S_IDLE) || (r_state == S_RETIRE));
        w_retire   = rst_n && (r_state == S_RETIRE);
        wb_valid   = w_retire;
        wb_pc      = w_retire ? r_pc : '0;
        wb_inst    = w_retire ? r_inst : '0;
        rf_waddr   = w_retire ? r_rw_addr : '0;
        rf_wdata   = '0;
        if (w_retire) begin
            rf_wdata = r_is_load ? r_ldata : r_rw_data;
        end
        rf_we      = w_retire && r_rw_en && (r_rw_addr != '0) && !r_timeout;
        wb_err     = rst_n && r_err;
    end

    always_comb begin
        w_byte = 8'h00;
        case (r_rw_data[1:0])
            2'd0: w_byte = ram_rdata[7:0];
            2'd1: w_byte = ram_rdata[15:8];
            2'd2: w_byte = ram_rdata[23:16];
            2'd3: w_byte = ram_rdata[31:24];
            default: w_byte = 8'h00;
        endcase
        w_half = r_rw_data[1] ? ram_rdata[31:16] : ram_rdata[15:0];
        case (r_inst[31:22])
            10'h0A0: w_ext = {{(DATA_WIDTH-8){w_byte[7]}}, w_byte};
            10'h0A8: w_ext = {{(DATA_WIDTH-8){1'b0}}, w_byte};
            10'h0A1: w_ext = {{(DATA_WIDTH-16){w_half[15]}}, w_half};
            10'h0A9: w_ext = {{(DATA_WIDTH-16){1'b0}}, w_half};
            default: w_ext = ram_rdata;
        endcase
    end

    // Accept and WAIT never overlap because wb_allowin is low in WAIT.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc      <= '0;
            r_inst    <= '0;
            r_is_load <= 1'b0;
            r_rw_data <= '0;
            r_rw_addr <= '0;
            r_rw_en   <= 1'b0;
            r_ldata   <= '0;
            r_cnt     <= '0;
            r_timeout <= 1'b0;
            r_err     <= 1'b0;
        end else if (w_accept) begin
            r_pc      <= mem_in.pc;
            r_inst    <= mem_in.inst;
            r_is_load <= mem_in.ram_rd_en;
            r_rw_data <= mem_in.rw_data;
            r_rw_addr <= mem_in.rw_addr;
            r_rw_en   <= mem_in.rw_en;
            r_ldata   <= '0;
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else if (r_state == S_WAIT) begin
            if (ram_rvalid) begin
                r_ldata <= w_ext;
            end else if (w_timeout_hit) begin
                r_timeout <= 1'b1;
                r_err     <= 1'b1;
            end else begin
                r_cnt <= r_cnt + 16'd1;
            end
        end
    end

endmodule
